// File: rtl/gs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gs_pkg
//  Description : Shared types and constants for the instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package gs_pkg;

    // PC source selection driven by the controller
    localparam logic [3:0] PC_BOOT   = 4'd0;
    localparam logic [3:0] PC_NORMAL = 4'd1;
    localparam logic [3:0] PC_BRANCH = 4'd2;
    localparam logic [3:0] PC_JUMP   = 4'd3;

    // Default prefetch buffer depth (entries)
    localparam int unsigned IF_FIFO_DEPTH_DEFAULT = 2;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_ABORT = 2'd2
    } if_state_t;

endpackage : gs_pkg
`default_nettype wire

// File: rtl/gs_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : gs_fetch_fifo
//  Description : Small circular prefetch buffer holding {pc, instruction}
//                pairs. Flush empties it in one edge; the head is forced to
//                zero while the buffer is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module gs_fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Pointer increment with wrap for non power-of-two depths
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign count_o    = count_q;
    assign do_push    = push_i & ~full_o & ~flush_i;
    assign do_pop     = pop_i & ~empty_o & ~flush_i;
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush wins over push and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; contents need no reset because the head is masked when empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule : gs_fetch_fifo
`default_nettype wire

// File: rtl/gs_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : gs_if_stage
//  Description : Instruction-fetch stage. Issues one request at a time to
//                instruction memory, buffers responses in a prefetch FIFO and
//                hands them to decode. Redirects with a request in flight go
//                through ABORT so the stale response is dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module gs_if_stage
    import gs_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = IF_FIFO_DEPTH_DEFAULT,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] boot_addr_i,
    input  logic              instr_fetch_i,
    input  logic [3:0]        pc_mux_sel_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    input  logic              flush_if_i,
    input  logic              halt_if_i,
    output logic              instr_req_o,
    output logic [ADDR_W-1:0] instr_addr_o,
    input  logic              instr_gnt_i,
    input  logic              instr_rvalid_i,
    input  logic [31:0]       instr_rdata_i,
    output logic              if_fetch_valid_o,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o,
    input  logic              id_ready_i,
    output logic              if_fetch_ready_o,
    output logic              instr_misaligned_o
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DATA_W = ADDR_W + 32;

    if_state_t         state_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] req_pc_q;
    logic              outstanding_q;
    logic              req_hold_q;
    logic              misaligned_q;

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              gnt_fire;
    logic              rsp_fire;
    logic              room;
    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign redirect = flush_if_i &
                      ((pc_mux_sel_i == PC_BRANCH) | (pc_mux_sel_i == PC_JUMP));
    assign target   = (pc_mux_sel_i == PC_JUMP) ? jump_target_i : branch_target_i;

    // Buffer space left once the in-flight response is accounted for
    assign room = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, outstanding_q})
                  < (CNT_W + 1)'(FIFO_DEPTH);

    // Single outstanding request; an unanswered request is held until granted
    // so halt cannot retract it (only a redirect clears the hold)
    assign instr_req_o  = (state_q == IF_FETCH) & ~outstanding_q &
                          (req_hold_q | (~halt_if_i & room & ~fifo_full));
    assign instr_addr_o = fetch_pc_q;
    assign gnt_fire     = instr_req_o & instr_gnt_i;
    assign rsp_fire     = (state_q == IF_FETCH) & outstanding_q & instr_rvalid_i;
    assign fifo_push    = rsp_fire & ~flush_if_i;

    assign if_fetch_valid_o   = ~fifo_empty & ~halt_if_i & ~flush_if_i;
    assign fifo_pop           = if_fetch_valid_o & id_ready_i;
    assign instr_o            = fifo_head[31:0];
    assign pc_o               = fifo_head[DATA_W-1:32];
    assign if_fetch_ready_o   = (state_q == IF_FETCH);
    assign instr_misaligned_o = misaligned_q;

    // Fetch sequencer: request bookkeeping, PC update and abort tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IF_IDLE;
            fetch_pc_q    <= '0;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            req_hold_q    <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            misaligned_q <= 1'b0;
            case (state_q)
                IF_IDLE: begin
                    outstanding_q <= 1'b0;
                    req_hold_q    <= 1'b0;
                    if (instr_fetch_i) begin
                        state_q    <= IF_FETCH;
                        fetch_pc_q <= boot_addr_i;
                    end
                end
                IF_FETCH: begin
                    req_hold_q <= instr_req_o & ~instr_gnt_i & ~redirect;
                    if (gnt_fire) begin
                        outstanding_q <= 1'b1;
                        req_pc_q      <= fetch_pc_q;
                        fetch_pc_q    <= fetch_pc_q + ADDR_W'(4);
                    end else if (rsp_fire) begin
                        outstanding_q <= 1'b0;
                    end
                    // Any flush leaving a granted request unanswered must
                    // swallow its response; a flush coinciding with rvalid
                    // simply drops that response here
                    if (flush_if_i && (gnt_fire || (outstanding_q && !instr_rvalid_i))) begin
                        state_q <= IF_ABORT;
                    end
                    if (redirect) begin
                        fetch_pc_q   <= {target[ADDR_W-1:2], 2'b00};
                        misaligned_q <= |target[1:0];
                    end
                end
                IF_ABORT: begin
                    req_hold_q <= 1'b0;
                    if (instr_rvalid_i) begin
                        state_q       <= IF_FETCH;
                        outstanding_q <= 1'b0;
                    end
                    if (redirect) begin
                        fetch_pc_q   <= {target[ADDR_W-1:2], 2'b00};
                        misaligned_q <= |target[1:0];
                    end
                end
                default: begin
                    state_q <= IF_IDLE;
                end
            endcase
        end
    end

    gs_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i ({req_pc_q, instr_rdata_i}),
        .pop_i       (fifo_pop),
        .flush_i     (flush_if_i),
        .pop_data_o  (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule : gs_if_stage
`default_nettype wire

// File: tb/tb_gs_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gs_if_stage
//  Description : Directed self-checking bench for the instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gs_if_stage;
    import gs_pkg::*;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] boot_addr_i;
    logic              instr_fetch_i;
    logic [3:0]        pc_mux_sel_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic [ADDR_W-1:0] jump_target_i;
    logic              flush_if_i;
    logic              halt_if_i;
    logic              instr_req_o;
    logic [ADDR_W-1:0] instr_addr_o;
    logic              instr_gnt_i;
    logic              instr_rvalid_i;
    logic [31:0]       instr_rdata_i;
    logic              if_fetch_valid_o;
    logic [31:0]       instr_o;
    logic [ADDR_W-1:0] pc_o;
    logic              id_ready_i;
    logic              if_fetch_ready_o;
    logic              instr_misaligned_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gs_if_stage #(
        .FIFO_DEPTH (2),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .boot_addr_i        (boot_addr_i),
        .instr_fetch_i      (instr_fetch_i),
        .pc_mux_sel_i       (pc_mux_sel_i),
        .branch_target_i    (branch_target_i),
        .jump_target_i      (jump_target_i),
        .flush_if_i         (flush_if_i),
        .halt_if_i          (halt_if_i),
        .instr_req_o        (instr_req_o),
        .instr_addr_o       (instr_addr_o),
        .instr_gnt_i        (instr_gnt_i),
        .instr_rvalid_i     (instr_rvalid_i),
        .instr_rdata_i      (instr_rdata_i),
        .if_fetch_valid_o   (if_fetch_valid_o),
        .instr_o            (instr_o),
        .pc_o               (pc_o),
        .id_ready_i         (id_ready_i),
        .if_fetch_ready_o   (if_fetch_ready_o),
        .instr_misaligned_o (instr_misaligned_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst             = 1'b1;
        boot_addr_i     = 32'h0000_0100;
        instr_fetch_i   = 1'b0;
        pc_mux_sel_i    = PC_NORMAL;
        branch_target_i = '0;
        jump_target_i   = '0;
        flush_if_i      = 1'b0;
        halt_if_i       = 1'b0;
        instr_gnt_i     = 1'b0;
        instr_rvalid_i  = 1'b0;
        instr_rdata_i   = '0;
        id_ready_i      = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_req",   instr_req_o, 0);
        check("rst_valid", if_fetch_valid_o, 0);
        check("rst_ready", if_fetch_ready_o, 0);
        check("rst_mis",   instr_misaligned_o, 0);
        check("rst_addr",  instr_addr_o, 0);
        check("rst_instr", instr_o, 0);
        check("rst_pc",    pc_o, 0);

        rst = 1'b0;
        id_ready_i = 1'b1;
        tick(); #1;
        check("idle_req",   instr_req_o, 0);
        check("idle_ready", if_fetch_ready_o, 0);

        // Boot sequence
        instr_fetch_i = 1'b1;
        tick();
        instr_fetch_i = 1'b0; #1;
        check("boot_ready", if_fetch_ready_o, 1);
        check("boot_req0",  instr_req_o, 1);
        check("boot_addr0", instr_addr_o, 32'h100);
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hAAAA_0001; #1;
        check("boot_early_valid", if_fetch_valid_o, 0);
        check("boot_one_outst",   instr_req_o, 0);
        tick();
        instr_rvalid_i = 1'b0; #1;
        check("boot_valid0", if_fetch_valid_o, 1);
        check("boot_pc0",    pc_o, 32'h100);
        check("boot_instr0", instr_o, 32'hAAAA_0001);
        check("boot_req1",   instr_req_o, 1);
        check("boot_addr1",  instr_addr_o, 32'h104);
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hAAAA_0002; #1;
        check("boot_popped", if_fetch_valid_o, 0);
        tick();
        instr_rvalid_i = 1'b0; #1;
        check("boot_pc1",    pc_o, 32'h104);
        check("boot_instr1", instr_o, 32'hAAAA_0002);
        check("boot_addr2",  instr_addr_o, 32'h108);
        check("boot_req2",   instr_req_o, 1);
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0; #1;
        check("boot_outst_req", instr_req_o, 0);

        // Branch with a response outstanding
        branch_target_i = 32'h200; pc_mux_sel_i = PC_BRANCH; flush_if_i = 1'b1; #1;
        check("br_flush_valid", if_fetch_valid_o, 0);
        tick();
        flush_if_i = 1'b0; pc_mux_sel_i = PC_NORMAL; #1;
        check("br_abort_ready", if_fetch_ready_o, 0);
        check("br_abort_req",   instr_req_o, 0);
        check("br_abort_addr",  instr_addr_o, 32'h200);
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'hDEAD_BEEF;
        tick();
        instr_rvalid_i = 1'b0; #1;
        check("br_back_ready", if_fetch_ready_o, 1);
        check("br_dropped",    if_fetch_valid_o, 0);
        check("br_req",        instr_req_o, 1);
        check("br_addr",       instr_addr_o, 32'h200);
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hBBBB_0200;
        tick();
        instr_rvalid_i = 1'b0; id_ready_i = 1'b0; #1;
        check("br_pc",    pc_o, 32'h200);
        check("br_instr", instr_o, 32'hBBBB_0200);
        check("br_addr1", instr_addr_o, 32'h204);

        // FIFO full with decode stalled
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hBBBB_0204;
        tick();
        instr_rvalid_i = 1'b0; instr_gnt_i = 1'b1; #1;
        check("full_req", instr_req_o, 0);
        repeat (3) tick();
        #1;
        check("full_req_hold", instr_req_o, 0);
        check("full_addr",     instr_addr_o, 32'h208);
        check("full_head",     pc_o, 32'h200);
        instr_gnt_i = 1'b0; id_ready_i = 1'b1;
        tick();
        id_ready_i = 1'b0; #1;
        check("pop1_pc",    pc_o, 32'h204);
        check("pop1_instr", instr_o, 32'hBBBB_0204);
        check("pop1_req",   instr_req_o, 1);
        check("pop1_addr",  instr_addr_o, 32'h208);
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0; #1;
        check("pop1_outst", instr_req_o, 0);
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'hBBBB_0208;
        tick();
        instr_rvalid_i = 1'b0; #1;
        check("refull_req", instr_req_o, 0);

        // Halt with one response in flight
        flush_if_i = 1'b1;
        tick();
        flush_if_i = 1'b0; id_ready_i = 1'b1; #1;
        check("fl_valid", if_fetch_valid_o, 0);
        check("fl_req",   instr_req_o, 1);
        check("fl_addr",  instr_addr_o, 32'h20C);
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0; halt_if_i = 1'b1; #1;
        check("halt_req0", instr_req_o, 0);
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'hCCCC_020C;
        tick();
        instr_rvalid_i = 1'b0; #1;
        check("halt_valid",  if_fetch_valid_o, 0);
        check("halt_req1",   instr_req_o, 0);
        check("halt_stored", instr_o, 32'hCCCC_020C);
        tick(); #1;
        check("halt_valid2", if_fetch_valid_o, 0);
        check("halt_req2",   instr_req_o, 0);
        halt_if_i = 1'b0; #1;
        check("rel_valid", if_fetch_valid_o, 1);
        check("rel_pc",    pc_o, 32'h20C);
        check("rel_req",   instr_req_o, 1);
        check("rel_addr",  instr_addr_o, 32'h210);
        tick(); #1;
        check("rel_popped", if_fetch_valid_o, 0);

        // Misaligned jump while a request is pending ungranted
        jump_target_i = 32'h302; pc_mux_sel_i = PC_JUMP; flush_if_i = 1'b1; #1;
        check("jmp_mis_before", instr_misaligned_o, 0);
        tick();
        flush_if_i = 1'b0; pc_mux_sel_i = PC_NORMAL; #1;
        check("jmp_mis",   instr_misaligned_o, 1);
        check("jmp_addr",  instr_addr_o, 32'h300);
        check("jmp_req",   instr_req_o, 1);
        check("jmp_ready", if_fetch_ready_o, 1);
        tick(); #1;
        check("jmp_mis_end", instr_misaligned_o, 0);
        check("jmp_addr2",   instr_addr_o, 32'h300);

        // Flush coinciding with rvalid: no abort, buffer empty
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i = 1'b0;
        branch_target_i = 32'h400; pc_mux_sel_i = PC_BRANCH; flush_if_i = 1'b1;
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'hEEEE_0300;
        tick();
        flush_if_i = 1'b0; pc_mux_sel_i = PC_NORMAL; instr_rvalid_i = 1'b0; #1;
        check("flrv_ready", if_fetch_ready_o, 1);
        check("flrv_valid", if_fetch_valid_o, 0);
        check("flrv_req",   instr_req_o, 1);
        check("flrv_addr",  instr_addr_o, 32'h400);

        // Asynchronous reset in the middle of a request
        #2;
        rst = 1'b1; #1;
        check("arst_req",   instr_req_o, 0);
        check("arst_addr",  instr_addr_o, 0);
        check("arst_ready", if_fetch_ready_o, 0);
        tick();
        rst = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'hFFFF_0000;
        tick();
        instr_rvalid_i = 1'b0; #1;
        check("late_rsp_valid", if_fetch_valid_o, 0);
        check("late_rsp_ready", if_fetch_ready_o, 0);
        check("late_rsp_pc",    pc_o, 0);

        // Flush in the same cycle as a grant enters ABORT
        boot_addr_i = 32'h500; instr_fetch_i = 1'b1;
        tick();
        instr_fetch_i = 1'b0; #1;
        check("fg_addr", instr_addr_o, 32'h500);
        check("fg_req",  instr_req_o, 1);
        flush_if_i = 1'b1; instr_gnt_i = 1'b1;
        tick();
        flush_if_i = 1'b0; instr_gnt_i = 1'b0; #1;
        check("fg_abort", if_fetch_ready_o, 0);
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'h1234_5678;
        tick();
        instr_rvalid_i = 1'b0; #1;
        check("fg_back", if_fetch_ready_o, 1);
        check("fg_drop", if_fetch_valid_o, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_gs_if_stage
`default_nettype wire
